// File: rtl/rtmc_pkg.sv
// Shared RTMC SPI definitions: command byte layout and initiator state encoding.
// Used by both the SPI target and the SPI initiator.
package rtmc_pkg;

  localparam int SPI_CMD_W      = 8;
  localparam int SPI_CMD_WR_BIT = 7;

  typedef enum logic [1:0] {
    IDLE,
    SETUP,
    SHIFT,
    GAP
  } spim_state_e;

  // Command byte: write flag in the top bit, register address below it.
  function automatic logic [SPI_CMD_W-1:0] spi_cmd(input logic                 wr,
                                                   input logic [SPI_CMD_W-2:0] addr);
    logic [SPI_CMD_W-1:0] c;
    c                 = {1'b0, addr};
    c[SPI_CMD_WR_BIT] = wr;
    return c;
  endfunction

endpackage

// File: rtl/rtmc_spi_baud.sv
// SPI half-period timer: one-cycle half_tick every CLK_DIV cycles while enabled.
// Reloads on start and is held at its reload value while disabled.
module rtmc_spi_baud #(
  parameter int CLK_DIV = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic en,
  input  logic start,
  output logic half_tick
);

  localparam int CNT_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [CNT_W-1:0] RELOAD = CNT_W'(CLK_DIV - 1);

  logic [CNT_W-1:0] r_cnt;

  always_ff @(posedge clk) begin
    if (!rst_n || !en || start) begin
      r_cnt <= RELOAD;
    end else if (r_cnt == '0) begin
      r_cnt <= RELOAD;
    end else begin
      r_cnt <= r_cnt - 1'b1;
    end
  end

  assign half_tick = en && (r_cnt == '0);

endmodule

// File: rtl/rtmc_spi_master.sv
// SPI mode-0 initiator issuing single RTMC register read/write frames:
// command byte {write, addr} followed by a DATA_W-bit data word, MSB first.
module rtmc_spi_master
  import rtmc_pkg::*;
#(
  parameter int CLK_DIV = 2,
  parameter int DATA_W  = 16,
  parameter int ADDR_W  = 7
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_write,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              rsp_valid,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              busy,
  output logic              sclk,
  output logic              cs,
  output logic              mosi,
  input  logic              miso
);

  localparam int N      = SPI_CMD_W + DATA_W;
  localparam int BCNT_W = $clog2(N + 1);

  spim_state_e       r_state;
  spim_state_e       w_next;
  logic              w_accept;
  logic              w_tick;
  logic              w_rise;
  logic              w_fall;
  logic              w_done;
  logic [N-1:0]      w_frame;

  logic [N-1:0]      r_tx;
  logic [DATA_W-1:0] r_rx;
  logic [BCNT_W-1:0] r_bitcnt;
  logic              r_write;
  logic              r_sclk;
  logic              r_cs;
  logic              r_ready;
  logic              r_busy;
  logic              r_rsp_valid;
  logic [DATA_W-1:0] r_rsp_rdata;

  assign w_accept = req_valid && r_ready;
  assign w_frame  = {spi_cmd(req_write, req_addr), (req_write ? req_wdata : '0)};

  rtmc_spi_baud #(
    .CLK_DIV (CLK_DIV)
  ) u_baud (
    .clk       (clk),
    .rst_n     (rst_n),
    .en        (r_state != IDLE),
    .start     (w_accept),
    .half_tick (w_tick)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // r_bitcnt holds bits not yet completed; it reaches zero at the last fall,
  // so the low phase of bit 0 ends with a move to GAP instead of another rise.
  always_comb begin
    w_next = r_state;
    w_rise = 1'b0;
    w_fall = 1'b0;
    w_done = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_accept) w_next = SETUP;
      end
      SETUP: begin
        if (w_tick) begin
          w_next = SHIFT;
          w_rise = 1'b1;
        end
      end
      SHIFT: begin
        if (w_tick) begin
          if (r_sclk) begin
            w_fall = 1'b1;
          end else if (r_bitcnt == '0) begin
            w_next = GAP;
            w_done = 1'b1;
          end else begin
            w_rise = 1'b1;
          end
        end
      end
      GAP: begin
        if (w_tick) w_next = IDLE;
      end
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_tx        <= '0;
      r_rx        <= '0;
      r_bitcnt    <= '0;
      r_write     <= 1'b0;
      r_sclk      <= 1'b0;
      r_cs        <= 1'b1;
      r_ready     <= 1'b0;
      r_busy      <= 1'b0;
      r_rsp_valid <= 1'b0;
      r_rsp_rdata <= '0;
    end else begin
      r_rsp_valid <= 1'b0;
      r_cs        <= !((w_next == SETUP) || (w_next == SHIFT));
      r_ready     <= (w_next == IDLE);
      r_busy      <= (w_next != IDLE);
      if (w_accept) begin
        r_tx     <= w_frame;
        r_rx     <= '0;
        r_bitcnt <= BCNT_W'(N);
        r_write  <= req_write;
      end
      // Only the data-phase samples (last DATA_W bits) land in r_rx.
      if (w_rise) begin
        r_sclk <= 1'b1;
        if (!r_write && (r_bitcnt <= BCNT_W'(DATA_W))) begin
          r_rx <= {r_rx[DATA_W-2:0], miso};
        end
      end
      if (w_fall) begin
        r_sclk   <= 1'b0;
        r_tx     <= {r_tx[N-2:0], 1'b0};
        r_bitcnt <= r_bitcnt - 1'b1;
      end
      if (w_done) begin
        r_rsp_valid <= 1'b1;
        r_rsp_rdata <= r_write ? '0 : r_rx;
      end
    end
  end

  assign req_ready = r_ready;
  assign busy      = r_busy;
  assign sclk      = r_sclk;
  assign cs        = r_cs;
  assign mosi      = r_tx[N-1];
  assign rsp_valid = r_rsp_valid;
  assign rsp_rdata = r_rsp_rdata;

endmodule

// File: doc/rtmc_spi_master.md
# rtmc_spi_master

SPI initiator that issues single register read/write frames to the RTMC SPI target over the same four-wire link: `sclk`, `cs`, `mosi` and `miso`. It is used on-chip for multi-RTMC daisy configurations and as the synthesizable stimulus driver in system-level benches. It accepts one request at a time over a valid/ready handshake, serializes a command byte plus a data word in SPI mode 0, MSB first, and returns captured read data with a one-cycle response strobe.

## Interface
Parameters:
- `CLK_DIV`, default 2: SPI half-period in `clk` cycles; legal range ≥1.
- `DATA_W`, default 16: data-phase width in bits.
- `ADDR_W`, default 7: register address width. Fixed by the command format; must be 7.

Ports:
- `clk` in 1: single system clock.
- `rst_n` in 1: reset, synchronous and active-low.
- `req_valid` in 1: request present.
- `req_ready` out 1: master idle and able to accept.
- `req_write` in 1: 1 = write, 0 = read.
- `req_addr` in `ADDR_W`: register address.
- `req_wdata` in `DATA_W`: write data; ignored for reads.
- `rsp_valid` out 1: one-cycle pulse when a frame completes.
- `rsp_rdata` out `DATA_W`: captured read data; 0 after writes.
- `busy` out 1: high from acceptance until `req_ready` reasserts.
- `sclk` out 1: SPI clock; idle low (CPOL=0).
- `cs` out 1: chip select, active low.
- `mosi` out 1: serial data to target.
- `miso` in 1: serial data from target.

## Operation
- **Frame:** N = 8 + `DATA_W` bits, MSB first.
  - Command byte is {`req_write`, `req_addr`}.
  - Data phase: `req_wdata` for writes, all zeros for reads.
- **Acceptance:** a request is accepted on the cycle where `req_valid && req_ready`. All request fields are latched on that cycle; later input changes have no effect on the frame.
- **States:**
  - IDLE → SETUP on acceptance.
  - SETUP → SHIFT after `CLK_DIV` cycles.
  - SHIFT → GAP after the low phase of bit 0.
  - GAP → IDLE after `CLK_DIV` cycles.
- **SETUP:** `cs`=0, `sclk`=0, `mosi` = frame bit N-1.
- **SHIFT:** each bit is `CLK_DIV` cycles with `sclk`=1, then `CLK_DIV` cycles with `sclk`=0.
  - `mosi` changes only on the first cycle of a low phase, never while `sclk`=1.
  - `miso` is registered on the cycle `sclk` goes 0→1.
  - Only the last `DATA_W` samples are shifted into `rsp_rdata`, and only for reads.
- **GAP:** `cs`=1, `sclk`=0, `mosi`=0.
  - `rsp_valid`=1 on the first GAP cycle only; `rsp_rdata` updates on that cycle and holds until the next `rsp_valid`.
  - `req_ready`=0 throughout.
- **Idle values:** whenever `cs`=1, `mosi`=0 and `sclk`=0.
- **Reset values:** `cs`=1, `sclk`=0, `mosi`=0, `req_ready`=0, `rsp_valid`=0, `rsp_rdata`=0, `busy`=0.
  - `req_ready` goes to 1 on the first cycle after `rst_n` is sampled high.
- **Reset mid-frame:** the next edge forces reset values, so `cs` returns high immediately. No `rsp_valid` is produced and the partial frame is discarded.
- **`req_valid` while busy:** not consumed and does not affect the current frame.
- **Back-to-back requests:** each is separated by at least `CLK_DIV` cycles of `cs` high.

## Timing
- All outputs are registered; `miso` has no combinational path to any output.
- Acceptance is at cycle 0. Cycle numbers below are relative to it.
- `cs` is low for cycles 1 … `CLK_DIV`·(1+2N), i.e. exactly `CLK_DIV`·(1+2N) cycles.
- The first `sclk` rise is at cycle `CLK_DIV`+1.
- Bit k (k=0 is the MSB) rises at cycle `CLK_DIV`·(1+2k)+1.
- `rsp_valid` and `cs`=1 occur at cycle `CLK_DIV`·(1+2N)+1.
- `req_ready`=1 again at cycle `CLK_DIV`·(2+2N)+1.
- Defaults (`CLK_DIV`=2, N=24): `cs` low for 98 cycles, `rsp_valid` at cycle 99, ready again at cycle 101.
- `sclk` period is 2·`CLK_DIV` cycles with a 50 % duty cycle.

## Structure
- Add to `rtmc_pkg`:
  - `SPI_CMD_W` = 8 and `SPI_CMD_WR_BIT` = 7.
  - `spim_state_e` enum: IDLE, SETUP, SHIFT, GAP.
  - These are shared with the target so command encoding lives in one place.
- One sub-module, `rtmc_spi_baud`:
  - Down-counter producing a one-cycle `half_tick` every `CLK_DIV` cycles.
  - Restarts on a `start` pulse and is held cleared in IDLE.
- Top-level holds the FSM, an N-bit transmit shift register, a `DATA_W`-bit receive shift register and a bit counter of width $clog2(N+1).

## Test plan
- **Write:** addr 0x05, data 0xBEEF, `CLK_DIV`=2 → target model samples 0x85 then 0xBEEF on 24 rising edges; `cs` low for exactly 98 cycles; `rsp_valid` at cycle 99; `rsp_rdata`=0.
- **Read:** addr 0x12, target drives 0xA5C3 → `mosi` carries 0x12 then 16 zeros; `rsp_rdata`=0xA5C3 with `rsp_valid` for one cycle.
- **Back-to-back:** `req_valid` held high for two queued requests → second accepted only at cycle 101; `cs` high for ≥2 cycles between frames; `mosi` stable whenever `sclk`=1.
- **Reset mid-frame:** assert `rst_n`=0 after the bit-10 rise → `cs`=1, `sclk`=0, no `rsp_valid`; the following write of 0x1234 to 0x01 completes correctly.
- **Fastest divider:** `CLK_DIV`=1, read returning 0xFFFF → `sclk` period 2 cycles; `cs` low 49 cycles; `rsp_rdata`=0xFFFF.
- **Input stability:** change `req_addr`/`req_wdata` and pulse `req_valid` mid-frame → transmitted bits match the latched request; no extra acceptance.
